// File: rtl/subleq_mem_loader.sv
// Program/data RAM for the subleq core, filled by a byte-stream loader that holds
// the core in reset until the image is in. Optional MMIO output via SUBLEQ_MMIO_OUT_EN.
module subleq_mem_loader #(
  parameter int               P_AW       = 8,
  parameter int               P_DW       = 8,
  parameter int               P_LOAD_LEN = 256,
  parameter logic [P_AW-1:0]  P_IO_ADDR  = 8'hFF
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [P_AW-1:0] i_cpu_raddr,
  output logic [P_DW-1:0] o_cpu_rdata,
  input  logic [P_AW-1:0] i_cpu_waddr,
  input  logic [P_DW-1:0] i_cpu_wdata,
  input  logic            i_cpu_we,
  output logic            o_cpu_rstn,
  input  logic            i_ld_start,
  input  logic            i_ld_valid,
  input  logic [P_DW-1:0] i_ld_data,
  input  logic            i_ld_last,
  output logic            o_ld_ready,
  output logic            o_loaded,
  output logic [P_DW-1:0] o_io_data,
  output logic            o_io_valid
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [P_AW:0] LP_LAST_CNT = (P_AW+1)'(P_LOAD_LEN - 1);

  logic [P_DW-1:0] mem_q [2**P_AW];
  state_t          state_q, state_d;
  logic [P_AW-1:0] ld_addr_q, ld_addr_d;
  logic [P_AW:0]   ld_cnt_q, ld_cnt_d;
  logic            cpu_rstn_q, loaded_q;
  logic            ld_xfer_s, cpu_wr_s, mem_we_s;
  logic [P_AW-1:0] mem_waddr_s;
  logic [P_DW-1:0] mem_wdata_s;

  // A start pulse wins over a same-cycle transfer, so the byte is dropped.
  assign o_ld_ready = (state_q == S_LOAD);
  assign ld_xfer_s  = i_ld_valid & o_ld_ready & ~i_ld_start;
  assign cpu_wr_s   = i_cpu_we & (state_q == S_RUN);

  // Next-state logic and RAM write-port arbitration between loader and CPU.
  always_comb begin
    state_d     = state_q;
    ld_addr_d   = ld_addr_q;
    ld_cnt_d    = ld_cnt_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = ld_addr_q;
    mem_wdata_s = i_ld_data;
    if (i_ld_start) begin
      state_d   = S_LOAD;
      ld_addr_d = {P_AW{1'b0}};
      ld_cnt_d  = {(P_AW+1){1'b0}};
    end else begin
      case (state_q)
        S_LOAD: begin
          if (ld_xfer_s) begin
            ld_addr_d = ld_addr_q + P_AW'(1);
            ld_cnt_d  = ld_cnt_q + (P_AW+1)'(1);
            if (i_ld_last || (ld_cnt_q == LP_LAST_CNT)) begin
              state_d = S_REL;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
        S_REL:   state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_LOAD;
      endcase
    end
    if (ld_xfer_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = ld_addr_q;
      mem_wdata_s = i_ld_data;
    end else if (cpu_wr_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = i_cpu_waddr;
      mem_wdata_s = i_cpu_wdata;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Control registers; core reset and loaded flag track entry into S_RUN.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_LOAD;
      ld_addr_q  <= {P_AW{1'b0}};
      ld_cnt_q   <= {(P_AW+1){1'b0}};
      cpu_rstn_q <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_addr_q  <= ld_addr_d;
      ld_cnt_q   <= ld_cnt_d;
      cpu_rstn_q <= (state_d == S_RUN);
      loaded_q   <= (state_d == S_RUN);
    end
  end

  // RAM array, deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign o_cpu_rdata = mem_q[i_cpu_raddr];
  assign o_cpu_rstn  = cpu_rstn_q;
  assign o_loaded    = loaded_q;

`ifdef SUBLEQ_MMIO_OUT_EN
  logic [P_DW-1:0] io_data_q;
  logic            io_valid_q;
  logic            io_hit_s;

  assign io_hit_s = cpu_wr_s & (i_cpu_waddr == P_IO_ADDR);

  // MMIO strobe lasts one cycle; the data byte holds until the next MMIO write.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      io_data_q  <= {P_DW{1'b0}};
      io_valid_q <= 1'b0;
    end else begin
      io_valid_q <= io_hit_s;
      if (io_hit_s) begin
        io_data_q <= i_cpu_wdata;
      end
    end
  end

  assign o_io_data  = io_data_q;
  assign o_io_valid = io_valid_q;
`else
  localparam logic [P_AW-1:0] LP_UNUSED_IO_ADDR = P_IO_ADDR;
  assign o_io_data  = {P_DW{1'b0}};
  assign o_io_valid = 1'b0;
`endif

endmodule

// File: tb/tb_subleq_mem_loader.sv
// Self-checking bench for subleq_mem_loader: vector table, directed load/reset
// sequences and randomized loads/CPU traffic against an array memory model.
`timescale 1ns/1ps
module tb_subleq_mem_loader;

  localparam int DEPTH = 256;
`ifdef SUBLEQ_MMIO_OUT_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic [7:0] i_cpu_raddr = 8'h00, i_cpu_waddr = 8'h00, i_cpu_wdata = 8'h00;
  logic       i_cpu_we = 1'b0;
  logic       i_ld_start = 1'b0, i_ld_valid = 1'b0, i_ld_last = 1'b0;
  logic [7:0] i_ld_data = 8'h00;
  logic [7:0] o_cpu_rdata, o_io_data;
  logic       o_cpu_rstn, o_ld_ready, o_loaded, o_io_valid;

  subleq_mem_loader #(.P_AW(8), .P_DW(8), .P_LOAD_LEN(256), .P_IO_ADDR(8'hFF)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_cpu_raddr(i_cpu_raddr), .o_cpu_rdata(o_cpu_rdata),
    .i_cpu_waddr(i_cpu_waddr), .i_cpu_wdata(i_cpu_wdata), .i_cpu_we(i_cpu_we),
    .o_cpu_rstn(o_cpu_rstn),
    .i_ld_start(i_ld_start), .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data),
    .i_ld_last(i_ld_last), .o_ld_ready(o_ld_ready), .o_loaded(o_loaded),
    .o_io_data(o_io_data), .o_io_valid(o_io_valid)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] model_mem [DEPTH];
  bit         model_known [DEPTH];
  int         ld_ptr = 0;

  typedef struct {
    logic       we;
    logic [7:0] waddr, wdata, raddr, exp_before, exp_after;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    i_ld_valid = 1'b1; i_ld_data = d; i_ld_last = last;
    #1;
    chk("ld_ready_during_load", o_ld_ready, 1'b1);
    tick();
    model_mem[ld_ptr] = d; model_known[ld_ptr] = 1'b1;
    ld_ptr = (ld_ptr + 1) % DEPTH;
    i_ld_valid = 1'b0; i_ld_last = 1'b0;
  endtask

  task automatic gap();
    i_ld_valid = 1'b0; i_ld_data = 8'($urandom);
    tick();
  endtask

  // Called right after the final transfer edge; a stray valid in S_REL must be ignored.
  task automatic chk_release(input string tag);
    i_ld_valid = 1'b1; i_ld_data = 8'hFF;
    #1;
    chk({tag, "_rel_cpu_rstn"}, o_cpu_rstn, 1'b0);
    chk({tag, "_rel_ready"}, o_ld_ready, 1'b0);
    chk({tag, "_rel_loaded"}, o_loaded, 1'b0);
    tick();
    i_ld_valid = 1'b0;
    #1;
    chk({tag, "_run_cpu_rstn"}, o_cpu_rstn, 1'b1);
    chk({tag, "_run_loaded"}, o_loaded, 1'b1);
    chk({tag, "_run_ready"}, o_ld_ready, 1'b0);
  endtask

  task automatic readback_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      if (model_known[a]) begin
        i_cpu_raddr = 8'(a);
        #1;
        chk({tag, "_readback"}, o_cpu_rdata, model_mem[a]);
        tick();
      end
    end
  endtask

  task automatic start_pulse();
    i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    ld_ptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) model_known[a] = 1'b0;
    vecs[0] = '{1'b1, 8'h10, 8'hC3, 8'h10, 8'h4A, 8'hC3};
    vecs[1] = '{1'b0, 8'h11, 8'h99, 8'h11, 8'h4B, 8'h4B};
    vecs[2] = '{1'b1, 8'h00, 8'h01, 8'h00, 8'h5A, 8'h01};
    vecs[3] = '{1'b1, 8'h20, 8'h77, 8'h21, 8'h7B, 8'h7B};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h10, 8'hC3, 8'hC3};
    vecs[5] = '{1'b1, 8'h20, 8'h88, 8'h20, 8'h77, 8'h88};

    // Reset state
    #3;
    chk("rst_cpu_rstn", o_cpu_rstn, 1'b0);
    chk("rst_loaded", o_loaded, 1'b0);
    chk("rst_ready", o_ld_ready, 1'b1);
    chk("rst_io_valid", o_io_valid, 1'b0);
    chk("rst_io_data", o_io_data, 8'h00);
    tick(); tick();
    i_rstn = 1'b1;
    #1;
    chk("post_rst_cpu_rstn", o_cpu_rstn, 1'b0);

    // Full 256-byte load with valid held high
    for (int a = 0; a < DEPTH; a++) send(8'(a) ^ 8'h5A, 1'b0);
    chk_release("full");
    readback_all("full");

    // Vector table of CPU writes in S_RUN, read before and after the edge
    foreach (vecs[i]) begin
      i_cpu_we = vecs[i].we; i_cpu_waddr = vecs[i].waddr;
      i_cpu_wdata = vecs[i].wdata; i_cpu_raddr = vecs[i].raddr;
      #1;
      chk("vec_rdata_before_edge", o_cpu_rdata, vecs[i].exp_before);
      tick();
      i_cpu_we = 1'b0;
      if (vecs[i].we) model_mem[vecs[i].waddr] = vecs[i].wdata;
      #1;
      chk("vec_rdata_after_edge", o_cpu_rdata, vecs[i].exp_after);
    end

    // Start pulse in S_RUN during a CPU write, then short load with toggling valid
    i_cpu_we = 1'b1; i_cpu_waddr = 8'h30; i_cpu_wdata = 8'hEE;
    start_pulse();
    i_cpu_we = 1'b0;
    model_known[8'h30] = 1'b0;
    #1;
    chk("restart_cpu_rstn", o_cpu_rstn, 1'b0);
    chk("restart_ready", o_ld_ready, 1'b1);
    chk("restart_loaded", o_loaded, 1'b0);
    send(8'h07, 1'b0); gap();
    send(8'h08, 1'b0); gap();
    send(8'h00, 1'b1);
    chk_release("short");
    readback_all("short");

    // CPU write in S_LOAD ignored; start beats a same-cycle transfer
    start_pulse();
    i_cpu_we = 1'b1; i_cpu_waddr = 8'h10; i_cpu_wdata = 8'h55;
    tick();
    i_cpu_we = 1'b0;
    i_ld_start = 1'b1; i_ld_valid = 1'b1; i_ld_data = 8'hAA;
    tick();
    i_ld_start = 1'b0; i_ld_valid = 1'b0;
    send(8'h3C, 1'b1);
    chk_release("prio");
    i_cpu_raddr = 8'h10; #1;
    chk("load_state_cpu_write_ignored", o_cpu_rdata, 8'hC3);
    i_cpu_raddr = 8'h01; #1;
    chk("dropped_byte_not_written", o_cpu_rdata, 8'h08);
    i_cpu_raddr = 8'h00; #1;
    chk("first_byte_after_start", o_cpu_rdata, 8'h3C);

    // Async reset after 100 bytes, then reload from address 0
    start_pulse();
    for (int k = 0; k < 100; k++) send(8'($urandom), 1'b0);
    i_rstn = 1'b0;
    #1;
    chk("midload_rst_cpu_rstn", o_cpu_rstn, 1'b0);
    chk("midload_rst_ready", o_ld_ready, 1'b1);
    tick();
    i_rstn = 1'b1;
    ld_ptr = 0;
    for (int k = 0; k < 5; k++) send(8'($urandom), k == 4);
    chk_release("reload");
    readback_all("reload");

    // Randomized loads and CPU traffic against the model
    for (int it = 0; it < 8; it++) begin
      int n;
      start_pulse();
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) begin
        int g;
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) gap();
        send(8'($urandom), k == n - 1);
      end
      chk_release("rnd");
      for (int k = 0; k < 30; k++) begin
        logic [7:0] ra;
        i_cpu_we = 1'($urandom_range(0, 1));
        i_cpu_waddr = 8'($urandom_range(0, 254));
        i_cpu_wdata = 8'($urandom);
        ra = ($urandom_range(0, 1) == 1) ? i_cpu_waddr : 8'($urandom);
        i_cpu_raddr = ra;
        #1;
        if (model_known[ra]) chk("rnd_rdata_before", o_cpu_rdata, model_mem[ra]);
        tick();
        if (i_cpu_we) begin
          model_mem[i_cpu_waddr] = i_cpu_wdata;
          model_known[i_cpu_waddr] = 1'b1;
        end
        i_cpu_we = 1'b0;
        #1;
        if (model_known[ra]) chk("rnd_rdata_after", o_cpu_rdata, model_mem[ra]);
      end
    end

    // MMIO: a non-IO write must not strobe; IO write behaviour depends on the build
    i_cpu_we = 1'b1; i_cpu_waddr = 8'hFE; i_cpu_wdata = 8'h12;
    tick();
    i_cpu_we = 1'b0;
    #1;
    chk("mmio_nonio_valid", o_io_valid, 1'b0);
    i_cpu_we = 1'b1; i_cpu_waddr = 8'hFF; i_cpu_wdata = 8'h41; i_cpu_raddr = 8'hFF;
    tick();
    i_cpu_we = 1'b0;
    #1;
    chk("mmio_valid", o_io_valid, MMIO ? 1'b1 : 1'b0);
    chk("mmio_data", o_io_data, MMIO ? 8'h41 : 8'h00);
    chk("mmio_mem_written", o_cpu_rdata, 8'h41);
    tick();
    chk("mmio_valid_one_cycle", o_io_valid, 1'b0);
    chk("mmio_data_hold", o_io_data, MMIO ? 8'h41 : 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
